// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: default sizing,
// the arbiter state encoding and one-hot/index conversion helpers.
package rr_arb_pkg;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // Encode a one-hot (or all-zero) vector to its bit index; zero maps to 0.
    function automatic logic [IDW-1:0] onehot_to_idx(input logic [N-1:0] vec);
        logic [IDW-1:0] idx;
        idx = {IDW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | (vec[i] ? IDW'(i) : {IDW{1'b0}});
        end
        return idx;
    endfunction

    // Expand an index into a one-hot vector.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] vec;
        vec      = {N{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Cyclic priority search: finds the first set request bit starting at ptr
// and wrapping around. Done as rotate -> lowest-bit priority encode ->
// un-rotate so the encoder itself stays a plain fixed-priority chain.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = rr_arb_pkg::N,
    parameter int IDW = rr_arb_pkg::IDW
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] pick_id
);

    logic [2*N-1:0] req_dbl_s;
    logic [N-1:0]   rot_s;
    logic [IDW-1:0] rot_idx_s;
    logic [IDW:0]   sum_s;

    // Rotate the request vector right by ptr so the top-priority slot is bit 0.
    always_comb begin
        req_dbl_s = {req, req} >> ptr;
        rot_s     = req_dbl_s[N-1:0];
    end

    // Fixed-priority encode of the rotated vector; lowest set bit wins.
    always_comb begin
        found     = 1'b0;
        rot_idx_s = {IDW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            found     = found | rot_s[i];
            rot_idx_s = rot_s[i] ? IDW'(i) : rot_idx_s;
        end
    end

    // Undo the rotation: add ptr back, modulo N.
    always_comb begin
        sum_s = {1'b0, rot_idx_s} + {1'b0, ptr};
        if (sum_s >= (IDW+1)'(N)) begin
            pick_id = IDW'(sum_s - (IDW+1)'(N));
        end else begin
            pick_id = sum_s[IDW-1:0];
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded grant tenure.
// A grant is held while the owner keeps its request up; after MAX_HOLD
// grant cycles the owner is pushed out if anyone else is waiting. Every
// change of owner passes through one dead TURN cycle with grant=0.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int N        = rr_arb_pkg::N,
    parameter int IDW      = rr_arb_pkg::IDW,
    parameter int MAX_HOLD = rr_arb_pkg::MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           preempt
);

    localparam int             HCW       = $clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    arb_state_e     state_q,       state_d;
    logic [IDW-1:0] ptr_q,         ptr_d;
    logic [HCW-1:0] hold_cnt_q,    hold_cnt_d;
    logic [N-1:0]   grant_q,       grant_d;
    logic [IDW-1:0] grant_id_q,    grant_id_d;
    logic           grant_valid_q, grant_valid_d;
    logic           preempt_q,     preempt_d;

    logic           pick_found_s;
    logic [IDW-1:0] pick_id_s;
    logic           owner_req_s;
    logic           others_req_s;
    logic [IDW-1:0] owner_next_s;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .found   (pick_found_s),
        .pick_id (pick_id_s)
    );

    // Owner status and the slot just after the owner (next round-robin start).
    always_comb begin
        owner_req_s  = req[grant_id_q];
        others_req_s = |(req & ~grant_q);
        if (grant_id_q == IDW'(N - 1)) begin
            owner_next_s = {IDW{1'b0}};
        end else begin
            owner_next_s = grant_id_q + IDW'(1);
        end
    end

    // Next-state and next-output logic; grant_id/valid are derived from grant.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        preempt_d  = 1'b0;

        case (state_q)
            IDLE, TURN: begin
                // Both states arbitrate from the current pointer; they differ
                // only in how they were entered.
                hold_cnt_d = {HCW{1'b0}};
                if (pick_found_s) begin
                    state_d = GRANT;
                    grant_d = idx_to_onehot(pick_id_s);
                end else begin
                    state_d = IDLE;
                    grant_d = {N{1'b0}};
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    // Voluntary release takes precedence over any timeout.
                    state_d    = TURN;
                    grant_d    = {N{1'b0}};
                    ptr_d      = owner_next_s;
                    hold_cnt_d = {HCW{1'b0}};
                end else if ((hold_cnt_q == HOLD_LAST) && others_req_s) begin
                    state_d    = TURN;
                    grant_d    = {N{1'b0}};
                    ptr_d      = owner_next_s;
                    hold_cnt_d = {HCW{1'b0}};
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end else begin
                    // Saturated with nobody else waiting: keep the grant.
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = {N{1'b0}};
                hold_cnt_d = {HCW{1'b0}};
            end
        endcase

        grant_id_d    = onehot_to_idx(grant_d);
        grant_valid_d = |grant_d;
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= {IDW{1'b0}};
            hold_cnt_q    <= {HCW{1'b0}};
            grant_q       <= {N{1'b0}};
            grant_id_q    <= {IDW{1'b0}};
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios followed by
// randomized request traffic, all compared to a behavioural reference.
module tb_rr_arbiter8;

    localparam int NR       = 8;
    localparam int HOLD_MAX = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       preempt;

    int n_vec;
    int n_bad;

    // Reference model: who owns the resource (-1 = nobody), for how many
    // cycles beyond the first, where the round-robin search starts, and
    // whether the last edge forcibly removed an owner.
    int m_owner;
    int m_tenure;
    int m_ptr;
    bit m_pre;

    rr_arbiter8 dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int model_pick(input logic [7:0] r, input int start);
        for (int k = 0; k < NR; k++) begin
            if (r[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_ptr    = 0;
        m_pre    = 1'b0;
    endtask

    // Advance the model by one clock edge given the request seen at that edge.
    task automatic model_clock(input logic [7:0] r);
        logic [7:0] others;
        int p;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            others = r & ~(8'd1 << m_owner);
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end else if (m_tenure == HOLD_MAX - 1 && others != 8'd0) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_tenure < HOLD_MAX - 1) begin
                m_tenure++;
            end
        end else begin
            p = model_pick(r, m_ptr);
            if (p >= 0) begin
                m_owner  = p;
                m_tenure = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check_val({tag, "_grant"}, grant, eg);
        check_val({tag, "_valid"}, grant_valid, (m_owner >= 0) ? 1 : 0);
        check_val({tag, "_preempt"}, preempt, m_pre);
        if (m_owner >= 0) check_val({tag, "_id"}, grant_id, m_owner);
    endtask

    task automatic step(input logic [7:0] r, input string tag);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_clock(r);
        #1;
        check_outputs(tag);
    endtask

    // Assert reset between clock edges and confirm the outputs clear at once.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        req = 8'd0;
        #1;
        check_val({tag, "_rst_grant"}, grant, 0);
        check_val({tag, "_rst_valid"}, grant_valid, 0);
        check_val({tag, "_rst_id"}, grant_id, 0);
        check_val({tag, "_rst_preempt"}, preempt, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int cnt3, cnt_pre, cnt_valid;

        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs("reset");

        // Single requester, latency 1.
        step(8'h04, "tp1");
        check_val("tp1_id2", grant_id, 2);

        // Handover 0 -> 7 through a dead cycle, then back to idle.
        async_reset("tp2");
        step(8'h81, "tp2a");
        check_val("tp2_id0", grant_id, 0);
        step(8'h80, "tp2b");
        check_val("tp2_dead", grant, 0);
        step(8'h80, "tp2c");
        check_val("tp2_id7", grant_id, 7);
        step(8'h00, "tp2d");
        step(8'h00, "tp2e");
        step(8'h82, "tp2f");
        check_val("tp2_ptr0", grant_id, 1);

        // Timeout preemption of requester 3 by requester 5.
        async_reset("tp3");
        cnt3 = 0;
        cnt_pre = 0;
        for (int i = 0; i < 24; i++) begin
            step(8'h28, "tp3");
            if (grant_valid && grant_id == 3'd3) cnt3++;
            if (preempt) cnt_pre++;
        end
        check_val("tp3_tenure", cnt3, HOLD_MAX);
        check_val("tp3_pulses", cnt_pre, 1);
        check_val("tp3_id5", grant_id, 5);

        // Lone requester keeps the grant indefinitely.
        async_reset("tp4");
        cnt_pre = 0;
        cnt_valid = 0;
        for (int i = 0; i < 40; i++) begin
            step(8'h02, "tp4");
            if (preempt) cnt_pre++;
            if (grant_valid && grant_id == 3'd1) cnt_valid++;
        end
        check_val("tp4_pulses", cnt_pre, 0);
        check_val("tp4_held", cnt_valid, 40);

        // Release coinciding with timeout: no pulse.
        async_reset("tp5");
        for (int i = 0; i < HOLD_MAX; i++) step(8'h48, "tp5");
        step(8'h40, "tp5r");
        check_val("tp5_nopulse", preempt, 0);
        check_val("tp5_dead", grant, 0);
        step(8'h40, "tp5g");
        check_val("tp5_id6", grant_id, 6);

        // Reset mid-grant after ptr has moved away from 0.
        async_reset("tp6");
        step(8'h04, "tp6a");
        step(8'h00, "tp6b");
        step(8'h04, "tp6c");
        step(8'h04, "tp6d");
        async_reset("tp6");
        step(8'h12, "tp6e");
        check_val("tp6_ptr0", grant_id, 1);

        // Randomized traffic: requests toggle rarely so tenures get long.
        async_reset("rnd");
        r = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset("rnd");
            r = r ^ 8'($urandom & $urandom & $urandom);
            step(r, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
